// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------
// uart_pkg - shared constants and types for the MMIO UART transmitter.
// Revision: 1.0
//------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_tx_fifo.sv
//------------------------------------------------------------------------
// tx_fifo - synchronous FIFO with extra-MSB pointers for full/empty/count.
// Revision: 1.0
//------------------------------------------------------------------------
`default_nettype none

module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is still taken when a pop frees a slot this cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == DEPTH_C);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
//------------------------------------------------------------------------
// uart_tx_mmio - memory-mapped 8N1 UART transmitter with TX FIFO.
// Revision: 1.0
//------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH = 8,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [1:0]       reg_sel;
  logic             wr_en;
  logic             rd_en;
  logic             push_req;
  logic             ovf_clr;
  logic             unused;

  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic [DIV_W-1:0] divisor;
  logic             overflow;
  logic [31:0]      status;
  logic [31:0]      rd_val;

  tx_state_t        state;
  tx_state_t        state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic             tx_n;
  logic             pop;
  logic             cnt_zero;

  assign reg_sel  = addr[3:2];
  assign wr_en    = cs && wr_rd;
  assign rd_en    = cs && !wr_rd;
  assign push_req = wr_en && (reg_sel == REG_TXDATA);
  assign ovf_clr  = wr_en && (reg_sel == REG_STATUS) && data_bus_write[ST_OVF];
  assign unused   = ^{addr[31:4], addr[1:0], data_bus_write[31:16]};
  assign cnt_zero = (cnt == '0);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (data_bus_write[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status               = '0;
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_BUSY]      = (state != IDLE);
    status[ST_OVF]       = overflow;
    status[ST_COUNT+:CW] = fifo_count;
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS:  rd_val = status;
      REG_DIVISOR: rd_val = {16'd0, divisor};
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor       <= DIV_RESET;
      overflow      <= 1'b0;
      data_bus_read <= '0;
    end else begin
      if (wr_en && (reg_sel == REG_DIVISOR)) divisor <= data_bus_write[DIV_W-1:0];
      // Only a push that finds the FIFO full with no simultaneous pop is lost.
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clr)                  overflow <= 1'b0;
      if (rd_en) data_bus_read <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!fifo_empty) state_n = START;
      START:   if (cnt_zero) state_n = DATA;
      DATA:    if (cnt_zero && (bit_idx == 3'd7)) state_n = STOP;
      STOP:    if (cnt_zero) state_n = fifo_empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // Every reload samples the live DIVISOR, so a rewrite lands on a bit boundary.
  always_comb begin
    pop       = 1'b0;
    cnt_n     = cnt;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          cnt_n   = divisor;
        end
      end
      START: begin
        if (cnt_zero) begin
          cnt_n     = divisor;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          cnt_n     = divisor;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          cnt_n = divisor;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_data;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        cnt_n = '0;
      end
    endcase

    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
//------------------------------------------------------------------------
// tb_uart_tx_mmio - directed self-checking bench for uart_tx_mmio.
// Revision: 1.0
//------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_mmio;
  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic line_s[$];
  logic exp_s[$];

  uart_tx_mmio #(
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .cs             (cs),
    .wr_rd          (wr_rd),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read),
    .tx             (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_write(input logic [1:0] off, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b1; addr = {28'd0, off, 2'b00}; data_bus_write = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    cs = 1'b0; wr_rd = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b0; addr = {28'd0, off, 2'b00};
    @(negedge clk);
    cs = 1'b0;
    d = data_bus_read;
  endtask

  task automatic capture_line(input int n);
    line_s.delete();
    repeat (n) begin
      @(negedge clk);
      line_s.push_back(tx);
    end
  endtask

  task automatic wait_start(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic void add_level(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_s.push_back(v);
  endfunction

  function automatic void add_frame(input logic [7:0] b, input int div);
    add_level(1'b0, div + 1);
    for (int i = 0; i < 8; i++) add_level(b[i], div + 1);
    add_level(1'b1, div + 1);
  endfunction

  function automatic int first_diff();
    if (line_s.size() != exp_s.size()) return 0;
    for (int i = 0; i < exp_s.size(); i++)
      if (line_s[i] !== exp_s[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || data_bus_read !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold: tx=%b rd=%h expected tx=1 rd=0", tx, data_bus_read);
      end
      cs = 1'($urandom); wr_rd = 1'($urandom); addr = $urandom; data_bus_write = $urandom;
    end
    @(negedge clk);
    cs = 1'b0; wr_rd = 1'b0; rst = 1'b1;
    bus_read(REG_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h2); end
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd433) begin errors++; $display("FAIL reset_divisor: got %0d expected 433", rd); end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic [31:0] rd_mid;
    int          idx;
    drive_write(REG_DIVISOR, 32'd3);
    drive_write(REG_TXDATA, 32'hA5);
    bus_idle();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_idle: tx=%b expected 1", tx); end
    exp_s.delete();
    add_frame(8'hA5, 3);
    fork
      capture_line(exp_s.size());
      begin
        repeat (10) @(negedge clk);
        bus_read(REG_STATUS, rd_mid);
      end
    join
    idx = first_diff();
    checks++;
    if (idx != -1) begin
      errors++;
      $display("FAIL single_frame: sample %0d tx=%b expected %b", idx, line_s[idx], exp_s[idx]);
    end
    checks++;
    if (rd_mid !== 32'h6) begin errors++; $display("FAIL single_busy: got %h expected %h", rd_mid, 32'h6); end
    bus_read(REG_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL single_done: got %h expected %h", rd, 32'h2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        ok;
    int          n0;
    int          idx;
    drive_write(REG_DIVISOR, 32'd1);
    bus_idle();
    exp_s.delete();
    for (int k = 0; k < 10; k++) add_frame(8'(k), 1);
    fork
      begin
        wait_start(100, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL b2b_start: tx=%b expected 0 within 100 cycles", tx);
        end else begin
          capture_line(exp_s.size());
          idx = first_diff();
          checks++;
          if (idx != -1) begin
            errors++;
            $display("FAIL b2b_frames: sample %0d tx=%b expected %b", idx, line_s[idx], exp_s[idx]);
          end
        end
      end
      begin
        drive_write(REG_TXDATA, 32'h00);
        n0 = cyc + 1;
        for (int k = 1; k < 9; k++) drive_write(REG_TXDATA, 32'(k));
        drive_write(REG_TXDATA, 32'hEE);
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== 32'h8D) begin errors++; $display("FAIL b2b_overflow: got %h expected %h", rd, 32'h8D); end
        while (cyc != n0 + 20) @(negedge clk);
        cs = 1'b1; wr_rd = 1'b1; addr = {28'd0, REG_TXDATA, 2'b00}; data_bus_write = 32'h09;
        @(negedge clk);
        cs = 1'b0; wr_rd = 1'b0;
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== 32'h8D) begin errors++; $display("FAIL b2b_full_pushpop: got %h expected %h", rd, 32'h8D); end
        drive_write(REG_STATUS, 32'h8);
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== 32'h85) begin errors++; $display("FAIL b2b_ovf_clear: got %h expected %h", rd, 32'h85); end
      end
    join
    bus_read(REG_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL b2b_done: got %h expected %h", rd, 32'h2); end
  endtask

  task automatic test_divisor_change();
    logic [31:0] rd;
    int          idx;
    drive_write(REG_DIVISOR, 32'd7);
    drive_write(REG_TXDATA, 32'h0F);
    bus_idle();
    exp_s.delete();
    add_level(1'b0, 8);
    add_level(1'b1, 8);
    add_level(1'b1, 8);
    add_level(1'b1, 8);
    add_level(1'b1, 2);
    for (int i = 0; i < 4; i++) add_level(1'b0, 2);
    add_level(1'b1, 2);
    fork
      capture_line(exp_s.size());
      begin
        repeat (25) @(negedge clk);
        cs = 1'b1; wr_rd = 1'b1; addr = {28'd0, REG_DIVISOR, 2'b00}; data_bus_write = 32'd1;
        @(negedge clk);
        cs = 1'b0; wr_rd = 1'b0;
      end
    join
    idx = first_diff();
    checks++;
    if (idx != -1) begin
      errors++;
      $display("FAIL div_change: sample %0d tx=%b expected %b", idx, line_s[idx], exp_s[idx]);
    end
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL div_readback: got %0d expected 1", rd); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int          idx;
    drive_write(REG_DIVISOR, 32'd3);
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL rstmid_div: got %0d expected 3", rd); end
    drive_write(REG_TXDATA, 32'h00);
    drive_write(REG_TXDATA, 32'h33);
    bus_idle();
    repeat (9) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_low: tx=%b expected 0", tx); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || data_bus_read !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_async: tx=%b rd=%h expected tx=1 rd=0", tx, data_bus_read);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus_read(REG_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL rstmid_status: got %h expected %h", rd, 32'h2); end
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd433) begin errors++; $display("FAIL rstmid_divisor: got %0d expected 433", rd); end
    drive_write(REG_DIVISOR, 32'd2);
    drive_write(REG_TXDATA, 32'h55);
    bus_idle();
    exp_s.delete();
    add_frame(8'h55, 2);
    capture_line(exp_s.size());
    idx = first_diff();
    checks++;
    if (idx != -1) begin
      errors++;
      $display("FAIL rstmid_frame: sample %0d tx=%b expected %b", idx, line_s[idx], exp_s[idx]);
    end
  endtask

  task automatic test_read_protocol();
    logic [31:0] rd;
    drive_write(REG_DIVISOR, 32'hFFFF_0005);
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd5) begin errors++; $display("FAIL rp_div_upper: got %h expected %h", rd, 32'd5); end
    drive_write(2'd3, 32'h1234);
    bus_read(REG_DIVISOR, rd);
    checks++;
    if (rd !== 32'd5) begin errors++; $display("FAIL rp_reserved_wr: got %h expected %h", rd, 32'd5); end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rp_reserved_rd: got %h expected 0", rd); end
    bus_read(REG_DIVISOR, rd);
    bus_read(REG_TXDATA, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rp_txdata_rd: got %h expected 0", rd); end
    bus_read(REG_DIVISOR, rd);
    @(negedge clk);
    cs = 1'b0; wr_rd = 1'b0; addr = {28'd0, REG_STATUS, 2'b00};
    @(negedge clk);
    checks++;
    if (data_bus_read !== 32'd5) begin errors++; $display("FAIL rp_cs_low: got %h expected %h", data_bus_read, 32'd5); end
    drive_write(REG_DIVISOR, 32'd9);
    bus_idle();
    checks++;
    if (data_bus_read !== 32'd5) begin errors++; $display("FAIL rp_write_hold: got %h expected %h", data_bus_read, 32'd5); end
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_divisor_change();
    test_reset_midframe();
    test_read_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
